dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the load/store control interface driven by the main controller's MemRead/MemWrite decode. It accepts one load or store request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs the byte, halfword or word access into an internal word array. It sign- or zero-extends load data, flags illegal requests with an error response, and returns exactly one response per accepted request.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states between accept and response; 0..15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- funct3  in  3  access size/sign, RV32I encoding.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- rdata  out  32  extended load data; 0 for stores and errors.
- err  out  1  qualifies resp_valid: the request was rejected.

## Operation
- States: IDLE, WAIT, RESP, ERR.
- IDLE: req_ready = 1. On req_valid, capture mem_read, mem_write, funct3, addr and wdata, then classify the request.
- Illegal requests go to ERR. A request is illegal if any of these hold:
  - mem_read == mem_write.
  - funct3 is not in {000, 001, 010, 100, 101} for loads, or not in {000, 001, 010} for stores.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - addr ≥ 4·DEPTH_WORDS.
- Legal requests go to WAIT, loading a counter with WAIT_CYCLES. If WAIT_CYCLES = 0, they go directly to RESP.
- WAIT: decrement the counter each cycle. Move to RESP on the cycle the counter reaches 1.
- RESP (one cycle): resp_valid = 1, err = 0, then return to IDLE.
  - Store: write the selected byte lanes of word addr[log2(DEPTH_WORDS)+1:2]. SB uses lane addr[1:0]. SH uses lanes {addr[1],0} and {addr[1],1}. SW uses all four lanes. Unselected lanes are unchanged. The write commits on the clock edge that ends RESP.
  - Store: rdata = 0.
  - Load: rdata is the addressed byte or halfword from the array contents at RESP, extended as follows:
    - LB/LH: sign-extend.
    - LBU/LHU: zero-extend.
    - LW: the whole word.
- ERR (one cycle): resp_valid = 1, err = 1, rdata = 0, no array write, then return to IDLE.
- Array contents are not reset and are X until first written.

## Timing
- Reset values: req_ready = 0 while reset is asserted, 1 in the first cycle after release (IDLE); resp_valid = 0, err = 0, rdata = 0; state = IDLE; counter = 0.
- Registered outputs only; no combinational path from any input to resp_valid, rdata or err.
- Latency, with the request accepted on edge T:
  - Legal request: resp_valid is high in the cycle after edge T+WAIT_CYCLES+1 (1 + WAIT_CYCLES cycles of delay).
  - Illegal request: resp_valid is high in the cycle after edge T+1.
- At most one request is outstanding. Request inputs are ignored while req_ready = 0.
- A new request may be accepted in the cycle immediately after RESP/ERR (one idle cycle minimum between responses).
- Back-to-back store then load to the same address returns the stored data, because the write commits before the load's RESP.
- Reset mid-operation returns to IDLE immediately and drops the response:
  - A store aborted before its RESP edge does not write.
  - A store whose write edge coincides with reset assertion does not write.

## Structure
- Shared package rv32i_mem_pkg:
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - typedef enum logic [1:0] dmem_state_t {IDLE, WAIT, RESP, ERR}.
- Sub-module load_align: combinational; takes (word, addr[1:0], funct3) and returns the extended 32-bit load value.
- The top level holds the FSM, counter, legality check, byte-enable generation and array.

## Test plan
- SW 0xDEADBEEF @ 0x10, then LW @ 0x10 with WAIT_CYCLES = 2 -> each resp_valid arrives 3 cycles after accept; load rdata = 0xDEADBEEF, err = 0.
- SB 0x80 @ 0x13 over word 0x00000000, then LB @ 0x13 and LBU @ 0x13 -> LB rdata = 0xFFFFFF80, LBU rdata = 0x00000080; LW @ 0x10 = 0x80000000.
- SH 0xABCD @ 0x22 over 0x11111111, then LH @ 0x22 and LW @ 0x20 -> LH rdata = 0xFFFFABCD; LW rdata = 0xABCD1111.
- Illegal requests LW @ 0x02, LH @ 0x01, SW @ 0x400 (DEPTH_WORDS = 256), and mem_read = mem_write = 1 -> each gives resp_valid with err = 1 after 1 cycle, rdata = 0, array unchanged.
- WAIT_CYCLES = 0: LW -> resp_valid in the cycle after accept; req_valid held high -> requests accepted every other cycle.
- Assert reset during WAIT of SW 0x12345678 @ 0x30 -> no resp_valid; all outputs at reset values; later LW @ 0x30 returns the prior contents.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 access encodings
// and the responder state type.
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import rv32i_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign sel_b = word[{byte_off, 3'b000} +: 8];
    assign sel_h = byte_off[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = '0;
        case (funct3)
            F3_B:    value = {{24{sel_b[7]}}, sel_b};
            F3_BU:   value = {24'b0, sel_b};
            F3_H:    value = {{16{sel_h[15]}}, sel_h};
            F3_HU:   value = {16'b0, sel_h};
            F3_W:    value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, fixed
// wait states, byte-lane writes into a word array and a single response pulse.
module dmem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BW = AW + 2;
    localparam int unsigned CW = 4;

    dmem_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          capture;
    logic          is_load_q;
    logic [2:0]    f3_q;
    logic [BW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          resp_valid_n, err_n;
    logic [31:0]   rdata_n;

    logic          f3_ok, align_ok, range_ok, legal;
    logic [3:0]    be;
    logic [31:0]   wd_lanes;
    logic          we;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, load_val;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE) && !reset;

    // Classify the request currently presented on the inputs.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = mem_read;
            default:          f3_ok = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   align_ok = !addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        range_ok = (addr[31:BW] == '0);
        legal    = (mem_read != mem_write) && f3_ok && align_ok && range_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            is_load_q  <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            resp_valid <= resp_valid_n;
            err        <= err_n;
            rdata      <= rdata_n;
            if (capture) begin
                is_load_q <= mem_read;
                f3_q      <= funct3;
                addr_q    <= addr[BW-1:0];
                wdata_q   <= wdata;
            end
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        capture      = 1'b0;
        resp_valid_n = 1'b0;
        err_n        = 1'b0;
        rdata_n      = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (!legal) begin
                        state_n = ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt <= CW'(1)) state_n = RESP;
            end
            RESP: begin
                resp_valid_n = 1'b1;
                rdata_n      = is_load_q ? load_val : '0;
                state_n      = IDLE;
            end
            ERR: begin
                resp_valid_n = 1'b1;
                err_n        = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data for SB/SH/SW.
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be       = 4'b0001 << addr_q[1:0];
                wd_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wd_lanes = wdata_q;
            end
        endcase
    end

    assign word_idx = addr_q[BW-1:2];
    assign we       = (state == RESP) && !is_load_q && !reset;
    assign rd_word  = mem[word_idx];

    // Array is intentionally unreset; the write lands on the edge ending RESP.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wd_lanes[8*i +: 8];
            end
        end
    end

    load_align u_load_align (
        .word     (rd_word),
        .byte_off (addr_q[1:0]),
        .funct3   (f3_q),
        .value    (load_val)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-level
// memory model; a second zero-wait instance covers back-to-back acceptance.
module tb_dmem_responder;
    import rv32i_mem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WC    = 2;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, mem_read, mem_write, resp_valid, err;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;

    logic        req_valid_b, req_ready_b, mem_read_b, mem_write_b, resp_valid_b, err_b;
    logic [2:0]  funct3_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mb [0:4*DEPTH-1];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
        .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata), .err(err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .funct3(funct3_b), .addr(addr_b),
        .wdata(wdata_b), .resp_valid(resp_valid_b), .rdata(rdata_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        int sz;
        sz = access_size(f3);
        if (rd == wr) return 0;
        if (sz == 0) return 0;
        if (wr && f3[2]) return 0;
        if ((a % sz) != 0) return 0;
        if (longint'(a) >= longint'(4 * DEPTH)) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [15:0] h;
        h = {mb[a+1], mb[a]};
        case (f3)
            3'd0:    return 32'($signed(mb[a]));
            3'd4:    return 32'(mb[a]);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < access_size(f3); i++) mb[a+i] = d[8*i +: 8];
    endtask

    // Issue one request on the main instance and check latency, err and rdata.
    task automatic do_req(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        int n;
        bit lg;
        logic [31:0] exp;
        lg  = model_legal(rd, wr, f3, a);
        exp = (lg && rd) ? model_load(f3, a) : 32'h0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (resp_valid !== 1'b1) begin
                req_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
                funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            end
        end while (resp_valid !== 1'b1 && n < 40);
        req_valid = 1'b0;
        check({tag, "_lat"}, 32'(n - 1), lg ? 32'(WC + 1) : 32'h1);
        check({tag, "_err"}, 32'(err), lg ? 32'h0 : 32'h1);
        check({tag, "_rdata"}, rdata, exp);
        last_rdata = rdata;
        if (lg && wr) model_store(f3, a, d);
    endtask

    initial begin
        int rcnt, ycnt;
        bit rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;

        reset = 1'b1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        req_valid_b = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0; funct3_b = '0;
        addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp", 32'(resp_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        #1;
        check("rel_ready", 32'(req_ready), 32'h1);
        @(negedge clk);

        // Directed cases
        do_req("sw_dead", 0, 1, F3_W, 32'h10, 32'hDEADBEEF);
        do_req("lw_dead", 1, 0, F3_W, 32'h10, 32'h0);
        check("lw_dead_const", last_rdata, 32'hDEADBEEF);
        do_req("sw_zero", 0, 1, F3_W, 32'h10, 32'h0);
        do_req("sb_80", 0, 1, F3_B, 32'h13, 32'h55555580);
        do_req("lb_80", 1, 0, F3_B, 32'h13, 32'h0);
        check("lb_const", last_rdata, 32'hFFFFFF80);
        do_req("lbu_80", 1, 0, F3_BU, 32'h13, 32'h0);
        check("lbu_const", last_rdata, 32'h00000080);
        do_req("lw_10", 1, 0, F3_W, 32'h10, 32'h0);
        check("lw10_const", last_rdata, 32'h80000000);
        do_req("sw_1111", 0, 1, F3_W, 32'h20, 32'h11111111);
        do_req("sh_abcd", 0, 1, F3_H, 32'h22, 32'h9999ABCD);
        do_req("lh_abcd", 1, 0, F3_H, 32'h22, 32'h0);
        check("lh_const", last_rdata, 32'hFFFFABCD);
        do_req("lw_20", 1, 0, F3_W, 32'h20, 32'h0);
        check("lw20_const", last_rdata, 32'hABCD1111);
        do_req("ill_lw2", 1, 0, F3_W, 32'h02, 32'h0);
        do_req("ill_lh1", 1, 0, F3_H, 32'h01, 32'h0);
        do_req("ill_sw400", 0, 1, F3_W, 32'h400, 32'h12345678);
        do_req("ill_rdwr", 1, 1, F3_W, 32'h10, 32'h12345678);
        do_req("ill_none", 0, 0, F3_W, 32'h10, 32'h12345678);
        do_req("ill_sbu", 0, 1, F3_BU, 32'h10, 32'h12345678);
        do_req("lw_last", 1, 0, F3_W, 32'h3FC, 32'h0);
        do_req("lw_10_after", 1, 0, F3_W, 32'h10, 32'h0);
        check("unchanged_const", last_rdata, 32'h80000000);

        // Reset during WAIT of a store must drop it
        do_req("sw_prior", 0, 1, F3_W, 32'h30, 32'h0BADF00D);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = F3_W;
        addr = 32'h30; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(req_ready), 32'h0);
        check("abort_resp", 32'(resp_valid), 32'h0);
        check("abort_err", 32'(err), 32'h0);
        check("abort_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid === 1'b1) rcnt++;
        end
        check("abort_noresp", 32'(rcnt), 32'h0);
        do_req("lw_prior", 1, 0, F3_W, 32'h30, 32'h0);
        check("abort_const", last_rdata, 32'h0BADF00D);

        // Randomized phase over an initialized region plus out-of-range addresses
        for (int w = 0; w < 16; w++) do_req("init", 0, 1, F3_W, 32'(4 * w), $urandom);
        for (int k = 0; k < 150; k++) begin
            rd = 1'($urandom);
            wr = ($urandom_range(0, 9) == 0) ? rd : !rd;
            f3 = 3'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 32'h400 + 32'($urandom_range(0, 4095));
                1:       a = {1'b1, 31'($urandom)};
                default: a = 32'($urandom_range(0, 63));
            endcase
            do_req("rand", rd, wr, f3, a, $urandom);
        end

        // Zero-wait instance: held request accepted every other cycle
        @(negedge clk);
        req_valid_b = 1'b1; mem_read_b = 1'b0; mem_write_b = 1'b1; funct3_b = F3_W;
        addr_b = 32'h4; wdata_b = 32'hCAFEF00D;
        rcnt = 0; ycnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (req_ready_b === 1'b1) ycnt++;
            if (resp_valid_b === 1'b1) rcnt++;
            @(negedge clk);
        end
        req_valid_b = 1'b0;
        check("w0_accepts", 32'(ycnt), 32'd6);
        check("w0_resps", 32'(rcnt), 32'd5);
        @(negedge clk);
        req_valid_b = 1'b1; mem_read_b = 1'b1; mem_write_b = 1'b0; funct3_b = F3_W; addr_b = 32'h4;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        @(negedge clk);
        check("w0_lw_early", 32'(resp_valid_b), 32'h0);
        @(negedge clk);
        check("w0_lw_resp", 32'(resp_valid_b), 32'h1);
        check("w0_lw_err", 32'(err_b), 32'h0);
        check("w0_lw_rdata", rdata_b, 32'hCAFEF00D);
        req_valid_b = 1'b1; mem_read_b = 1'b0; mem_write_b = 1'b1; funct3_b = F3_W; addr_b = 32'h40;
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w0_oor_resp", 32'(resp_valid_b), 32'h1);
        check("w0_oor_err", 32'(err_b), 32'h1);
        check("w0_oor_rdata", rdata_b, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
